// File: rtl/shared_resource_unit_if.sv
// Pipeline <-> shared-resource handshake: operand/flush in, result/flush/stall back.
// The slave modport is the resource side; master is the pipeline side.
interface shared_resource_unit_if;
  logic [31:0] in_data_from_pipeline;
  logic        in_valid_from_pipeline;
  logic        in_flush_from_pipeline;
  logic        in_stall_from_pipeline;
  logic [31:0] out_data_to_pipeline;
  logic        out_valid_to_pipeline;
  logic        out_flush_to_pipeline;
  logic        out_stall_to_pipeline;

  modport slave (
    input  in_data_from_pipeline, in_valid_from_pipeline,
           in_flush_from_pipeline, in_stall_from_pipeline,
    output out_data_to_pipeline, out_valid_to_pipeline,
           out_flush_to_pipeline, out_stall_to_pipeline
  );

  modport master (
    output in_data_from_pipeline, in_valid_from_pipeline,
           in_flush_from_pipeline, in_stall_from_pipeline,
    input  out_data_to_pipeline, out_valid_to_pipeline,
           out_flush_to_pipeline, out_stall_to_pipeline
  );
endinterface

// File: rtl/shared_resource_unit.sv
// Shared-resource responder: input FIFO feeding a single-issue multi-cycle engine
// computing (operand ^ XOR_KEY) + ADD_CONST, with result hold under return-stage stall.
module shared_resource_unit #(
  parameter int          DEPTH     = 2,
  parameter int          LATENCY   = 3,
  parameter logic [31:0] XOR_KEY   = 32'h0000_00FF,
  parameter logic [31:0] ADD_CONST = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_resource_unit_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     occ_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [31:0]       res_q, res_d;
  logic              vld_q, vld_d;
  logic              flush_q;
  logic              full, empty, push, pop;

  // Stall comes from registered occupancy only, so a same-cycle pop cannot unstall.
  assign full  = (occ_q == CW'(DEPTH));
  assign empty = (occ_q == '0);
  assign push  = bus.in_valid_from_pipeline & ~full & ~bus.in_flush_from_pipeline;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        opnd_d  = mem_q[rptr_q];
        cnt_d   = CNTW'(LATENCY - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        res_d   = (opnd_q ^ XOR_KEY) + ADD_CONST;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (!bus.in_stall_from_pipeline) begin
        vld_d = 1'b0;
        if (!empty) begin
          // Back-to-back: next operand enters the engine on the transfer edge.
          pop     = 1'b1;
          opnd_d  = mem_q[rptr_q];
          cnt_d   = CNTW'(LATENCY - 1);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.in_flush_from_pipeline) begin
      pop     = 1'b0;
      vld_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      flush_q <= bus.in_flush_from_pipeline;
      if (bus.in_flush_from_pipeline) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        unique case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.in_data_from_pipeline;
  end

  assign bus.out_data_to_pipeline  = res_q;
  assign bus.out_valid_to_pipeline = vld_q;
  assign bus.out_flush_to_pipeline = flush_q;
  assign bus.out_stall_to_pipeline = full;
endmodule

// File: tb/tb_shared_resource_unit.sv
// Bench for shared_resource_unit: vector table plus directed corner sequences,
// results checked through an expected-value queue filled on accepted beats.
module tb_shared_resource_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_resource_unit_if bus();
  shared_resource_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] sb [$];
  int          xfer_cyc [$];
  logic [31:0] exp_next;
  bit          acc;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  function automatic logic [31:0] model(input logic [31:0] d);
    return (d ^ 32'h0000_00FF) + 32'h0000_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + acceptor, evaluated away from the active edge on the values the next edge will see.
  always @(negedge clk) begin
    acc = 1'b0;
    if (reset || bus.in_flush_from_pipeline) begin
      sb.delete();
    end else begin
      if (bus.out_valid_to_pipeline && !bus.in_stall_from_pipeline) begin
        if (sb.size() == 0) check("unexpected_valid", {31'b0, bus.out_valid_to_pipeline}, 32'd0);
        else begin
          check("result", bus.out_data_to_pipeline, sb.pop_front());
          xfer_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid_from_pipeline && !bus.out_stall_to_pipeline) begin
        sb.push_back(exp_next);
        acc = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [31:0] e);
    bit ok = 1'b0;
    bus.in_data_from_pipeline  = d;
    bus.in_valid_from_pipeline = 1'b1;
    exp_next = e;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (acc) begin ok = 1'b1; break; end
    end
    #1;
    bus.in_valid_from_pipeline = 1'b0;
    if (!ok) check("send_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    if (!ok) check("drain_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      at_neg();
      if (bus.out_valid_to_pipeline) begin ok = 1'b1; break; end
    end
    if (!ok) check("valid_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic latency_check(input logic [31:0] d);
    send(d, model(d));
    for (int k = 0; k < 6; k++) begin
      at_neg();
      check("lat_valid", {31'b0, bus.out_valid_to_pipeline}, (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1234_5678, 32'h1234_5688};
    vecs[1] = '{32'hFFFF_FF00, 32'h0000_0000};
    vecs[2] = '{32'h0000_00FF, 32'h0000_0001};
    vecs[3] = '{32'h0000_0000, 32'h0000_0100};
    vecs[4] = '{32'h0000_0010, 32'h0000_00F0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FF01};
    vecs[6] = '{32'h8000_0000, 32'h8000_0100};
    vecs[7] = '{32'h0000_0002, 32'h0000_00FE};

    reset = 1'b1;
    bus.in_data_from_pipeline  = '0;
    bus.in_valid_from_pipeline = 1'b0;
    bus.in_flush_from_pipeline = 1'b0;
    bus.in_stall_from_pipeline = 1'b0;
    exp_next = '0;
    repeat (3) tick();
    reset = 1'b0;
    at_neg();
    check("rst_data",  bus.out_data_to_pipeline, 32'd0);
    check("rst_valid", {31'b0, bus.out_valid_to_pipeline}, 32'd0);
    check("rst_flush", {31'b0, bus.out_flush_to_pipeline}, 32'd0);
    check("rst_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].din, vecs[i].exp);
      wait_drain();
    end

    latency_check(32'h1234_5678);

    // Backpressure: three beats fill engine + FIFO, fourth is held off.
    bus.in_stall_from_pipeline = 1'b1;
    xfer_cyc.delete();
    send(32'h1, model(32'h1));
    send(32'h2, model(32'h2));
    send(32'h3, model(32'h3));
    bus.in_data_from_pipeline  = 32'h4;
    bus.in_valid_from_pipeline = 1'b1;
    exp_next = model(32'h4);
    at_neg();
    check("full_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd1);
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      check("held_data",  bus.out_data_to_pipeline, 32'h0000_00FF);
      check("held_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd1);
      at_neg();
    end
    tick();
    bus.in_stall_from_pipeline = 1'b0;
    at_neg();
    check("pushpop_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd1);
    check("pushpop_noacc", {31'b0, acc}, 32'd0);
    tick();
    at_neg();
    check("next_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd0);
    check("next_acc",   {31'b0, acc}, 32'd1);
    tick();
    bus.in_valid_from_pipeline = 1'b0;
    wait_drain();
    check("bp_count", xfer_cyc.size(), 32'd4);
    for (int k = 1; k < xfer_cyc.size(); k++)
      check("bp_spacing", xfer_cyc[k] - xfer_cyc[k-1], 32'd4);

    // Flush while BUSY with one FIFO entry pending; a beat presented in the flush cycle is dropped.
    send(32'h20, model(32'h20));
    send(32'h21, model(32'h21));
    bus.in_flush_from_pipeline = 1'b1;
    bus.in_data_from_pipeline  = 32'h55;
    bus.in_valid_from_pipeline = 1'b1;
    exp_next = model(32'h55);
    at_neg();
    check("flush_pre", {31'b0, bus.out_flush_to_pipeline}, 32'd0);
    tick();
    bus.in_flush_from_pipeline = 1'b0;
    bus.in_valid_from_pipeline = 1'b0;
    at_neg();
    check("flush_pulse", {31'b0, bus.out_flush_to_pipeline}, 32'd1);
    check("flush_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      if (k == 0) check("flush_end", {31'b0, bus.out_flush_to_pipeline}, 32'd0);
      check("flush_novalid", {31'b0, bus.out_valid_to_pipeline}, 32'd0);
    end
    tick();
    send(32'h10, 32'h0000_00F0);
    wait_drain();

    // Reset during HOLD with a beat still queued.
    bus.in_stall_from_pipeline = 1'b1;
    send(32'h30, model(32'h30));
    send(32'h31, model(32'h31));
    wait_valid();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    at_neg();
    check("rst2_data",  bus.out_data_to_pipeline, 32'd0);
    check("rst2_valid", {31'b0, bus.out_valid_to_pipeline}, 32'd0);
    check("rst2_flush", {31'b0, bus.out_flush_to_pipeline}, 32'd0);
    check("rst2_stall", {31'b0, bus.out_stall_to_pipeline}, 32'd0);
    bus.in_stall_from_pipeline = 1'b0;
    tick();
    latency_check(32'h40);
    wait_drain();
    repeat (5) tick();
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
